// File: rtl/data_mem_uart_dumper.sv
// rtl/data_mem_uart_dumper.sv - Streams a DATA_RAM word range out as UART bytes (optional DUMP_PARITY_EN adds even parity, 8E1)
module data_mem_uart_dumper #(
    parameter int DATA_MEM_WIDTH      = 12,
    parameter int DATA_MEM_ADDR_WIDTH = 12,
    parameter int CLKS_PER_BIT        = 868
) (
    input  logic                           clk,
    input  logic                           rstN,
    input  logic                           startN,
    input  logic [DATA_MEM_ADDR_WIDTH-1:0] baseAddr,
    input  logic [DATA_MEM_ADDR_WIDTH:0]   wordCount,
    input  logic [DATA_MEM_WIDTH-1:0]      memDataIn,
    output logic [DATA_MEM_ADDR_WIDTH-1:0] memAddr,
    output logic                           tx,
    output logic                           busy,
    output logic                           done
);
    localparam int NB  = (DATA_MEM_WIDTH + 7) / 8;
    localparam int WB  = NB * 8;
    localparam int CW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIW = (NB > 1) ? $clog2(NB) : 1;
    localparam int AW  = DATA_MEM_ADDR_WIDTH;

    localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BIW-1:0] BYTE_LAST = BIW'(NB - 1);
    localparam logic [AW:0]    ONE_WORD  = (AW+1)'(1);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        WAIT,
        LOAD,
        START,
        DATA,
`ifdef DUMP_PARITY_EN
        PARITY,
`endif
        STOP,
        DONE
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   addr_q;
    logic [AW:0]     rem_q;
    logic [WB-1:0]   word_q;
    logic [7:0]      shift_q;
    logic [CW-1:0]   baud_q;
    logic [2:0]      bit_q;
    logic [BIW-1:0]  byte_q;
    logic            tx_q;
    logic            busy_q;
    logic            done_q;
`ifdef DUMP_PARITY_EN
    logic            parity_q;
`endif

    logic baud_end;
    assign baud_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            word_q   <= '0;
            shift_q  <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef DUMP_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (!startN) begin
                        rem_q <= wordCount;
                        if (wordCount == '0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q  <= baseAddr;
                            state_q <= ADDR;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                ADDR: state_q <= WAIT;
                WAIT: begin
                    word_q  <= WB'(memDataIn);
                    state_q <= LOAD;
                end
                LOAD: begin
                    // Low byte goes out first; word_q keeps the bytes still pending.
                    byte_q   <= '0;
                    shift_q  <= word_q[7:0];
                    word_q   <= word_q >> 8;
`ifdef DUMP_PARITY_EN
                    parity_q <= ^word_q[7:0];
`endif
                    tx_q     <= 1'b0;
                    baud_q   <= '0;
                    state_q  <= START;
                end
                START: begin
                    if (baud_end) begin
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        bit_q   <= '0;
                        baud_q  <= '0;
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
`ifdef DUMP_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                            bit_q   <= bit_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`ifdef DUMP_PARITY_EN
                PARITY: begin
                    if (baud_end) begin
                        tx_q    <= 1'b1;
                        baud_q  <= '0;
                        state_q <= STOP;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (byte_q != BYTE_LAST) begin
                            byte_q   <= byte_q + 1'b1;
                            shift_q  <= word_q[7:0];
                            word_q   <= word_q >> 8;
`ifdef DUMP_PARITY_EN
                            parity_q <= ^word_q[7:0];
`endif
                            tx_q     <= 1'b0;
                            state_q  <= START;
                        end else if (rem_q > ONE_WORD) begin
                            // Address wraps modulo the RAM size by natural overflow.
                            rem_q   <= rem_q - 1'b1;
                            addr_q  <= addr_q + 1'b1;
                            state_q <= ADDR;
                        end else begin
                            rem_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign memAddr = addr_q;
    assign tx      = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_data_mem_uart_dumper.sv
// tb/tb_data_mem_uart_dumper.sv - Self-checking bench for data_mem_uart_dumper against a cycle-level waveform model
module tb_data_mem_uart_dumper;
    localparam int W    = 12;
    localparam int AW   = 12;
    localparam int CPB  = 4;
    localparam int NB   = (W + 7) / 8;
    localparam int MAXS = 2048;
`ifdef DUMP_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic          clk = 1'b0;
    logic          rstN;
    logic          startN;
    logic [AW-1:0] baseAddr;
    logic [AW:0]   wordCount;
    logic [W-1:0]  memDataIn;
    logic [AW-1:0] memAddr;
    logic          tx;
    logic          busy;
    logic          done;

    data_mem_uart_dumper #(
        .DATA_MEM_WIDTH(W), .DATA_MEM_ADDR_WIDTH(AW), .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk), .rstN(rstN), .startN(startN), .baseAddr(baseAddr),
        .wordCount(wordCount), .memDataIn(memDataIn), .memAddr(memAddr),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [W-1:0] ram [0:4095];
    always @(posedge clk) memDataIn <= ram[memAddr];

    int total = 0;
    int bad   = 0;

    bit            exp_tx [$];
    int            exp_len;
    bit            cap_tx   [0:MAXS-1];
    bit            cap_busy [0:MAXS-1];
    bit            cap_done [0:MAXS-1];
    logic [AW-1:0] cap_addr [0:MAXS-1];
    logic [2:0]    diff_act, diff_exp;
    int            seen_n;

    // Expected tx per sample after the start edge: 3 fetch cycles, framed bytes, 3-cycle gaps.
    function automatic void build_expected(input logic [AW-1:0] base, input int cnt);
        logic [W-1:0]  w;
        logic [7:0]    bv;
        logic [AW-1:0] a;
        exp_tx.delete();
        if (cnt > 0) repeat (3) exp_tx.push_back(1'b1);
        for (int j = 0; j < cnt; j++) begin
            a = base + AW'(j);
            w = ram[a];
            for (int b = 0; b < NB; b++) begin
                bv = 8'((w >> (8 * b)) & 'hFF);
                repeat (CPB) exp_tx.push_back(1'b0);
                for (int i = 0; i < 8; i++) repeat (CPB) exp_tx.push_back(bv[i]);
`ifdef DUMP_PARITY_EN
                repeat (CPB) exp_tx.push_back(^bv);
`endif
                repeat (CPB) exp_tx.push_back(1'b1);
            end
            if (j < cnt - 1) repeat (3) exp_tx.push_back(1'b1);
        end
        exp_len = exp_tx.size();
    endfunction

    function automatic int wave_diff();
        bit et, eb, ed;
        for (int k = 0; k < exp_len + 2; k++) begin
            et = (k < exp_len) ? exp_tx[k] : 1'b1;
            eb = (k < exp_len);
            ed = (k >= exp_len);
            if (cap_tx[k] != et || cap_busy[k] != eb || cap_done[k] != ed) begin
                diff_act = {cap_tx[k], cap_busy[k], cap_done[k]};
                diff_exp = {et, eb, ed};
                return k;
            end
        end
        return -1;
    endfunction

    function automatic bit addr_seq_ok(input logic [AW-1:0] base, input int cnt);
        logic [AW-1:0] seen [$];
        bit ok;
        for (int k = 0; k < exp_len; k++)
            if (seen.size() == 0 || cap_addr[k] != seen[seen.size()-1]) seen.push_back(cap_addr[k]);
        seen_n = seen.size();
        ok = (seen.size() == cnt);
        for (int j = 0; j < cnt && ok; j++)
            if (seen[j] != base + AW'(j)) ok = 1'b0;
        return ok;
    endfunction

    // Starts a dump and records one sample per cycle; startN may be held or re-pulsed with junk inputs.
    task automatic run_dump(input logic [AW-1:0] base, input int cnt, input int hold, input int glitch);
        build_expected(base, cnt);
        @(negedge clk);
        baseAddr  = base;
        wordCount = (AW+1)'(cnt);
        startN    = 1'b0;
        for (int k = 0; k < exp_len + 2; k++) begin
            @(negedge clk);
            cap_tx[k]   = tx;
            cap_busy[k] = busy;
            cap_done[k] = done;
            cap_addr[k] = memAddr;
            if (k < hold - 1 || k == glitch) begin
                startN    = 1'b0;
                baseAddr  = AW'($urandom);
                wordCount = (AW+1)'($urandom_range(0, 5));
            end else begin
                startN = 1'b1;
            end
        end
        startN = 1'b1;
    endtask

    task automatic test_reset();
        rstN = 1'b0; startN = 1'b1; baseAddr = '0; wordCount = '0;
        repeat (3) @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got %b want 1", tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
        total++; if (memAddr !== '0) begin bad++; $display("FAIL reset_addr got %h want 000", memAddr); end
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_two_byte_word();
        int d;
        logic [7:0] b0, b1;
        ram[5] = 12'hABC;
        run_dump(12'h005, 1, 1, -1);
        total++; d = wave_diff();
        if (d >= 0) begin bad++; $display("FAIL two_byte_wave at %0d got tx/busy/done=%b want %b", d, diff_act, diff_exp); end
        total++; if (!(cap_tx[2] == 1'b1 && cap_tx[3] == 1'b0)) begin
            bad++; $display("FAIL two_byte_fall got tx[2],tx[3]=%b%b want 10", cap_tx[2], cap_tx[3]);
        end
        for (int i = 0; i < 8; i++) begin
            b0[i] = cap_tx[3 + CPB * (1 + i) + 1];
            b1[i] = cap_tx[3 + FB * CPB + CPB * (1 + i) + 1];
        end
        total++; if (b0 !== 8'hBC) begin bad++; $display("FAIL two_byte_b0 got %h want bc", b0); end
        total++; if (b1 !== 8'h0A) begin bad++; $display("FAIL two_byte_b1 got %h want 0a", b1); end
        total++; if (!(cap_done[3 + 2*FB*CPB] == 1'b1 && cap_done[2 + 2*FB*CPB] == 1'b0 && cap_busy[3 + 2*FB*CPB] == 1'b0)) begin
            bad++; $display("FAIL two_byte_done_edge got done %b%b busy %b want 01 0",
                cap_done[2 + 2*FB*CPB], cap_done[3 + 2*FB*CPB], cap_busy[3 + 2*FB*CPB]);
        end
    endtask

    task automatic test_wrap();
        int d;
        ram[12'hFFE] = 12'h111; ram[12'hFFF] = 12'h222; ram[12'h000] = 12'h333;
        run_dump(12'hFFE, 3, 1, -1);
        total++; d = wave_diff();
        if (d >= 0) begin bad++; $display("FAIL wrap_wave at %0d got tx/busy/done=%b want %b", d, diff_act, diff_exp); end
        total++; if (!addr_seq_ok(12'hFFE, 3)) begin bad++; $display("FAIL wrap_addr got %0d distinct addresses (last %h) want 3 ending 000", seen_n, cap_addr[exp_len-1]); end
    endtask

    task automatic test_zero_count();
        int d;
        run_dump(AW'($urandom), 0, 1, -1);
        total++; d = wave_diff();
        if (d >= 0) begin bad++; $display("FAIL zero_wave at %0d got tx/busy/done=%b want %b", d, diff_act, diff_exp); end
    endtask

    task automatic test_mid_start_ignored();
        int d;
        logic [AW-1:0] base;
        base = AW'($urandom);
        run_dump(base, 2, 1, 30);
        total++; d = wave_diff();
        if (d >= 0) begin bad++; $display("FAIL mid_start_wave at %0d got tx/busy/done=%b want %b", d, diff_act, diff_exp); end
        total++; if (!addr_seq_ok(base, 2)) begin bad++; $display("FAIL mid_start_addr got %0d addresses want 2", seen_n); end
    endtask

    task automatic test_restart_from_done();
        int d;
        logic [AW-1:0] base;
        base = AW'($urandom);
        run_dump(base, 2, 3, -1);
        total++; d = wave_diff();
        if (d >= 0) begin bad++; $display("FAIL restart_wave at %0d got tx/busy/done=%b want %b", d, diff_act, diff_exp); end
        total++; if (!addr_seq_ok(base, 2)) begin bad++; $display("FAIL restart_addr got %0d addresses want 2", seen_n); end
    endtask

    task automatic test_reset_mid_frame();
        int d;
        bit quiet;
        @(negedge clk);
        baseAddr = AW'($urandom); wordCount = 13'd2; startN = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            startN = 1'b1;
        end
        rstN = 1'b0;
        @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL midrst_tx got %b want 1", tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got %b want 0", done); end
        rstN = 1'b1;
        quiet = 1'b1;
        repeat (3 * CPB) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
        end
        total++; if (!quiet) begin bad++; $display("FAIL midrst_idle got activity after reset want idle"); end
        run_dump(AW'($urandom), 2, 1, -1);
        total++; d = wave_diff();
        if (d >= 0) begin bad++; $display("FAIL midrst_fresh_wave at %0d got tx/busy/done=%b want %b", d, diff_act, diff_exp); end
    endtask

    task automatic test_random();
        int d, cnt, gl;
        logic [AW-1:0] base;
        for (int r = 0; r < 4; r++) begin
            base = AW'($urandom);
            cnt  = $urandom_range(1, 4);
            gl   = ($urandom_range(0, 1) == 1) ? $urandom_range(5, 60) : -1;
            run_dump(base, cnt, 1, gl);
            total++; d = wave_diff();
            if (d >= 0) begin bad++; $display("FAIL random%0d_wave at %0d got tx/busy/done=%b want %b", r, d, diff_act, diff_exp); end
            total++; if (!addr_seq_ok(base, cnt)) begin bad++; $display("FAIL random%0d_addr got %0d addresses want %0d", r, seen_n, cnt); end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = W'($urandom);
        test_reset();
        test_two_byte_word();
        test_wrap();
        test_zero_count();
        test_mid_start_ignored();
        test_restart_from_done();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
